online_otf_converter: RTL and testbench
=======================================

# online_otf_converter

Downstream consumer of the online subtraction/addition stages. Accepts a most-significant-digit-first stream of radix-2 signed digits in borrow-save encoding, one digit per handshake. Performs on-the-fly conversion into a two's-complement word with no carry-propagate adder. Presents the completed word through a valid/ready output handshake to the Newton-iteration datapath.

## Interface
- `N`, default 8: digits per operand, N ≥ 2. Result width is N+1.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `x`  in  2  signed digit: value = x[1] − x[0]. 10=+1, 01=−1, 00 and 11 = 0.
- `In_vld`  in  1  upstream digit valid.
- `In_rdy`  out  1  converter accepts a digit this cycle.
- `res`  out  N+1  two's-complement result = Σ d_i·2^(N−i), i=1..N; sign bit is res[N].
- `Out_vld`  out  1  `res` holds a completed conversion.
- `Out_rdy`  in  1  downstream accepts `res`.

## Operation
- Two states. S_ACC: `In_rdy`=1, `Out_vld`=0. S_OUT: `In_rdy`=0, `Out_vld`=1.
- `In_rdy` and `Out_vld` are pure decodes of the state register, with no combinational path from inputs.
- A digit transfer occurs on a rising edge with `In_vld`=1 and `In_rdy`=1. `x` is ignored otherwise.
- Registers Q and QM are N+1 bits wide, plus a digit counter `cnt` of width clog2(N+1).
- Q/QM update per accepted digit d (shift left, append LSB):
  - d=+1: Q←{Q,1}, QM←{Q,0}.
  - d=0: Q←{Q,0}, QM←{QM,1}.
  - d=−1: Q←{QM,1}, QM←{QM,0}.
  - The MSB shifted out is discarded.
- Invariant: QM = Q − 1 (mod 2^(N+1)) after every update.
- Initial values: Q=0, QM=all ones.
- `cnt` increments per accepted digit. The accept that brings `cnt` to N moves S_ACC→S_OUT.
- On that same edge, the updated Q is loaded into `res`.
- S_OUT: `res` and `Out_vld` are held stable while `Out_rdy`=0.
- S_OUT with `Out_rdy`=1: go to S_ACC; clear Q→0, QM→all ones, cnt→0. `res` retains its last value.
- Range: input value lies in [−(2^N−1), 2^N−1], so it always fits in N+1 bits. There is no overflow case.
- Encoding 11 is legal and treated exactly as 0.

## Timing
- Reset values: `In_rdy`=1, `Out_vld`=0, `res`=0. Internal: Q=0, QM=all ones, cnt=0, state=S_ACC.
- Reset asserted mid-stream discards the partial conversion. The first digit after release is digit 1 of a new operand.
- Throughput is one digit per cycle while `In_vld` is held high.
- Latency: `Out_vld` rises the cycle after the edge that accepts digit N.
- Output handshake completes on the edge with `Out_vld`=1 and `Out_rdy`=1.
  - `In_rdy`=1 in the following cycle.
  - Minimum gap between last digit of operand k and first digit of operand k+1: 2 cycles (one S_OUT cycle, then accept).
- `In_vld` asserted during S_OUT is not accepted and produces no side effect.

## Structure
- Shared package `online_pkg` holds:
  - digit constants `SD_POS`=2'b10, `SD_NEG`=2'b01, `SD_ZERO`=2'b00;
  - the state enum {S_ACC, S_OUT};
  - a function decoding a 2-bit digit to {+1, 0, −1}. The online adders reuse this function.
- Single module. The Q/QM update is small enough that no sub-module is warranted.

## Test plan
All cases use N=8.
- Single-digit magnitude: digits +1,0,0,0,0,0,0,0 → `res`=9'h080. Digits −1,0,0,0,0,0,0,0 → `res`=9'h180.
- Redundant representation and 11 encoding:
  - +1,−1,0,0,0,0,0,0 → 9'h040.
  - 0×7 then −1 → 9'h1FF.
  - Digit 1 encoded 11, followed by +1×7 → 9'h07F.
- Extremes: eight +1 → 9'h0FF. Eight −1 → 9'h101.
- Backpressure: after digit 8, hold `Out_rdy`=0 for 3 cycles while `In_vld`=1 with `x`=10.
  - `Out_vld`=1, `res` stable, `In_rdy`=0 throughout.
  - After `Out_rdy` pulses, the next operand converts correctly with no stale digits.
- Input gaps: toggle `In_vld` randomly during an operand → same result as the gap-free stream. `Out_vld` rises exactly one cycle after the 8th accept.
- Reset mid-operation: assert `rst_n`=0 asynchronously after 4 digits.
  - Outputs take their reset values immediately.
  - A following full stream +1,0×7 yields 9'h080.

Source files
------------

// File: rtl/online_pkg.sv
// Shared definitions for the online arithmetic stages: signed-digit codes,
// converter state encoding and the borrow-save digit decoder.
package online_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } otf_state_e;

  // Borrow-save digit value x[1] - x[0]; 11 is a redundant zero.
  function automatic logic signed [1:0] sd_decode(input logic [1:0] d);
    case (d)
      SD_POS:  return 2'sd1;
      SD_NEG:  return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/online_otf_converter.sv
// On-the-fly conversion of an MSD-first radix-2 signed-digit stream into a
// two's-complement word, handed off through a valid/ready output port.
module online_otf_converter
  import online_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   x,
  input  logic         In_vld,
  output logic         In_rdy,
  input  logic         Out_rdy,
  output logic [N:0]   res,
  output logic         Out_vld
);

  localparam int unsigned W  = N + 1;
  localparam int unsigned CW = $clog2(N + 1);

  otf_state_e          state_q, state_d;
  logic [W-1:0]        q, qm, q_nxt, qm_nxt;
  logic [CW-1:0]       cnt;
  logic signed [1:0]   dig;
  logic                accept, last, release_out;

  assign In_rdy  = (state_q == S_ACC);
  assign Out_vld = (state_q == S_OUT);

  assign accept      = In_rdy && In_vld;
  assign last        = accept && (cnt == CW'(N - 1));
  assign release_out = Out_vld && Out_rdy;

  // Q/QM selection keeps QM == Q - 1 so no carry ever propagates.
  always_comb begin
    q_nxt  = q;
    qm_nxt = qm;
    dig    = sd_decode(x);
    if (dig == 2'sd1) begin
      q_nxt  = {q[W-2:0], 1'b1};
      qm_nxt = {q[W-2:0], 1'b0};
    end else if (dig == -2'sd1) begin
      q_nxt  = {qm[W-2:0], 1'b1};
      qm_nxt = {qm[W-2:0], 1'b0};
    end else begin
      q_nxt  = {q[W-2:0], 1'b0};
      qm_nxt = {qm[W-2:0], 1'b1};
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (last) state_d = S_OUT;
      S_OUT:   if (Out_rdy) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_ACC;
    else        state_q <= state_d;
  end

  // Conversion registers and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      qm  <= '1;
      cnt <= '0;
      res <= '0;
    end else if (accept) begin
      q   <= q_nxt;
      qm  <= qm_nxt;
      cnt <= cnt + CW'(1);
      if (last) res <= q_nxt;
    end else if (release_out) begin
      q   <= '0;
      qm  <= '1;
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_online_otf_converter.sv
// Self-checking bench for online_otf_converter (N=8): directed test-plan
// streams plus random digit streams with gaps and output backpressure.
module tb_online_otf_converter;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   x;
  logic         In_vld;
  logic         In_rdy;
  logic         Out_rdy;
  logic [N:0]   res;
  logic         Out_vld;

  int unsigned  n_chk = 0;
  int unsigned  n_err = 0;
  logic [1:0]   dig [N];

  online_otf_converter #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (x),
    .In_vld  (In_vld),
    .In_rdy  (In_rdy),
    .Out_rdy (Out_rdy),
    .res     (res),
    .Out_vld (Out_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: value = sum d_i * 2^(N-i), reduced to N+1 bits.
  function automatic logic [N:0] model_value();
    int val = 0;
    for (int i = 0; i < int'(N); i++)
      val += (int'(dig[i][1]) - int'(dig[i][0])) * (1 << (int'(N) - 1 - i));
    return (N+1)'(val);
  endfunction

  function automatic logic [1:0] rand_digit();
    int unsigned r = $urandom_range(3);
    case (r)
      0:       return 2'b10;
      1:       return 2'b01;
      2:       return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  task automatic load_word(input logic [15:0] w);
    for (int i = 0; i < int'(N); i++) dig[i] = w[15-2*i -: 2];
  endtask

  // Drive one operand from dig[], then hold the output for `hold` cycles.
  task automatic run_operand(input logic [N:0] exp, input int gap_pct, input int hold);
    for (int i = 0; i < int'(N); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        In_vld = 1'b0;
        x      = 2'($urandom);
        @(negedge clk);
        check("gap_out_vld", Out_vld, 0);
      end
      check("in_rdy_acc", In_rdy, 1);
      In_vld = 1'b1;
      x      = dig[i];
      @(negedge clk);
      if (i < int'(N) - 1) check("out_vld_early", Out_vld, 0);
    end
    In_vld = 1'b0;
    check("out_vld_rise", Out_vld, 1);
    check("in_rdy_out", In_rdy, 0);
    check("res", res, exp);
    for (int h = 0; h < hold; h++) begin
      In_vld  = 1'b1;
      x       = 2'b10;
      Out_rdy = 1'b0;
      @(negedge clk);
      check("hold_out_vld", Out_vld, 1);
      check("hold_in_rdy", In_rdy, 0);
      check("hold_res", res, exp);
    end
    In_vld  = 1'b0;
    Out_rdy = 1'b1;
    @(negedge clk);
    Out_rdy = 1'b0;
    check("post_in_rdy", In_rdy, 1);
    check("post_out_vld", Out_vld, 0);
    check("post_res", res, exp);
  endtask

  logic [15:0] dir_w   [7];
  logic [N:0]  dir_exp [7];

  initial begin
    dir_w   = '{16'h8000, 16'h4000, 16'h9000, 16'h0001, 16'hEAAA, 16'hAAAA, 16'h5555};
    dir_exp = '{9'h080, 9'h180, 9'h040, 9'h1FF, 9'h07F, 9'h0FF, 9'h101};

    rst_n   = 1'b0;
    x       = 2'b00;
    In_vld  = 1'b0;
    Out_rdy = 1'b0;
    #12;
    check("rst_in_rdy", In_rdy, 1);
    check("rst_out_vld", Out_vld, 0);
    check("rst_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      load_word(dir_w[k]);
      check("model_directed", model_value(), dir_exp[k]);
      run_operand(dir_exp[k], 0, (k == 0) ? 3 : 0);
    end

    // Backpressure then an immediate new operand with no stale digits.
    load_word(16'h5555);
    run_operand(9'h101, 0, 3);
    load_word(16'h8000);
    run_operand(9'h080, 0, 0);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < int'(N); i++) dig[i] = rand_digit();
      run_operand(model_value(), (k % 2 == 0) ? 35 : 0, int'($urandom_range(3)));
    end

    // Asynchronous reset after four digits.
    for (int i = 0; i < 4; i++) begin
      In_vld = 1'b1;
      x      = 2'b10;
      @(negedge clk);
    end
    In_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_rdy", In_rdy, 1);
    check("mid_rst_out_vld", Out_vld, 0);
    check("mid_rst_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_word(16'h8000);
    run_operand(9'h080, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
